conv_enc_framer: RTL and testbench
==================================

CONV_ENC_FRAMER -- requirements
Module: conv_enc_framer

Interface
REQ-001 Parameter: FRAME_LEN, 256, number of data bits per frame (legal range 2..65535).
REQ-002 Parameter: ERR_PERIOD, 7, error-injection interval in valid symbols (legal range 2..255); used only when CONV_ERR_INJ_EN is defined.
REQ-003 Port: clk  input  1  single clock; all logic on rising edge.
REQ-004 Port: rst  input  1  synchronous reset, active-low.
REQ-005 Port: enable_encoder_i  input  1  source valid; a bit is accepted on any edge where enable_encoder_i=1 and ready_o=1.
REQ-006 Port: encoder_i  input  1  source data bit.
REQ-007 Port: ready_o  output  1  block can accept a data bit.
REQ-008 Port: encoder_o  output  2  coded symbol; [1]=G0 (octal 7), [0]=G1 (octal 5).
REQ-009 Port: valid_o  output  1  encoder_o holds a new symbol this cycle.
REQ-010 Port: sof_o  output  1  first symbol of a frame.
REQ-011 Port: eof_o  output  1  last tail symbol of a frame.
REQ-012 Port: word_ct  output  16  completed-frame count.
REQ-013 Port: err_inj  output  1  current symbol has been corrupted.
REQ-014 Port: bad_bit_ct  output  16  total corrupted bits.

Function
REQ-015 Encoder shall be rate 1/2, K=3, with state s[1:0], where s[1] is the most recent bit: G0=u^s[1]^s[0], G1=u^s[0], next state {u,s[1]}.
REQ-016 Outputs shall be registered: a bit accepted at edge n shall appear on encoder_o, with valid_o=1, after edge n and be held until edge n+1.
REQ-017 FSM states: IDLE, DATA, TAIL.
- IDLE->DATA on the first accepted bit.
- DATA->TAIL on acceptance of bit number FRAME_LEN.
- TAIL->IDLE after two tail symbols.
REQ-018 ready_o shall be 1 in IDLE and DATA and 0 in TAIL.
REQ-019 TAIL shall emit exactly 2 symbols on consecutive cycles with u=0, ignoring encoder_i and enable_encoder_i; s shall be 00 on return to IDLE.
REQ-020 In IDLE/DATA with enable_encoder_i=0: valid_o=0, s and the bit counter held, encoder_o held at its last value.
REQ-021 sof_o shall be 1 only with the symbol of bit 1; eof_o shall be 1 only with the second tail symbol; both are otherwise 0.
REQ-022 word_ct shall increment in the cycle eof_o is asserted and wrap from 65535 to 0.
REQ-023 An accepted bit in the same cycle as DATA->TAIL shall be encoded normally; the next frame may start in the cycle after eof_o (IDLE accepts immediately).

Reset
REQ-024 rst=0 at an edge shall set: FSM=IDLE, s=00, bit counter=0, encoder_o=00, valid_o=0, sof_o=0, eof_o=0, word_ct=0, err_inj=0, bad_bit_ct=0, and ready_o=1 after that edge.
REQ-025 Reset mid-frame or mid-TAIL shall abandon the frame with no tail and no word_ct increment.

Configuration
REQ-026 With macro CONV_ERR_INJ_EN defined:
- Every ERR_PERIOD-th valid symbol counted since reset (data and tail) shall have encoder_o[0] inverted and err_inj=1.
- bad_bit_ct shall increment per corrupted symbol, saturating at 65535.
REQ-027 Without CONV_ERR_INJ_EN: no corruption logic, err_inj tied 0, bad_bit_ct tied 0.

Verification
REQ-028 Impulse: FRAME_LEN=4, input 1,0,0,0 continuous -> encoder_o 11,10,11,00,00,00 on 6 consecutive valid cycles; sof_o on 1st symbol, eof_o on 6th symbol.
REQ-029 Frame: FRAME_LEN=4, input 1,0,1,1 -> 11,10,00,01 then tail 01,11; ready_o=0 for exactly 2 cycles; word_ct 0->1.
REQ-030 Gaps: the same input as REQ-029 with enable_encoder_i=0 for 3 cycles between bits 2 and 3 -> identical symbol sequence, valid_o=0 during the gap.
REQ-031 Reset mid-frame: rst=0 after bit 2 -> all outputs at reset values and word_ct=0; the next frame 1,0,0,0 reproduces REQ-028.
REQ-032 CONV_ERR_INJ_EN, ERR_PERIOD=7, FRAME_LEN=256, 3 back-to-back frames (774 symbols) -> err_inj on symbols 7,14,...,770; bad_bit_ct=110; all other symbols match the reference encoder output.
REQ-033 Back-to-back frames: enable_encoder_i held 1 for 3 frames, FRAME_LEN=256 -> 774 valid symbols in 774 cycles; word_ct=3.

Source files
------------

// File: rtl/conv_enc_framer.sv
// Rate-1/2 K=3 convolutional encoder (G0=7, G1=5 octal) with FRAME_LEN-bit framing and a 2-symbol zero tail.
// Optional CONV_ERR_INJ_EN macro enables periodic corruption of encoder_o[0] every ERR_PERIOD valid symbols.
module conv_enc_framer #(
  parameter int FRAME_LEN  = 256,
  parameter int ERR_PERIOD = 7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable_encoder_i,
  input  logic        encoder_i,
  output logic        ready_o,
  output logic [1:0]  encoder_o,
  output logic        valid_o,
  output logic        sof_o,
  output logic        eof_o,
  output logic [15:0] word_ct,
  output logic        err_inj,
  output logic [15:0] bad_bit_ct
);

  typedef enum logic [1:0] {IDLE, DATA, TAIL} state_t;

  localparam logic [15:0] LAST_BIT = 16'(FRAME_LEN - 1);

  if (FRAME_LEN < 2 || FRAME_LEN > 65535 || ERR_PERIOD < 2 || ERR_PERIOD > 255) begin : g_param_range
    $error("conv_enc_framer: FRAME_LEN or ERR_PERIOD out of range");
  end

  state_t      state_q, state_d;
  logic [1:0]  s_q, s_d;
  logic [15:0] cnt_q, cnt_d;
  logic        tail_q, tail_d;
  logic [1:0]  enc_q, enc_d;
  logic        valid_q, valid_d;
  logic        sof_q, sof_d;
  logic        eof_q, eof_d;
  logic [15:0] word_q, word_d;
  logic        emit;
  logic        u;
  logic        err_flip;

  // A symbol is produced on every TAIL cycle and on every accepted data bit.
  assign emit    = (state_q == TAIL) || enable_encoder_i;
  assign u       = (state_q != TAIL) && encoder_i;
  assign ready_o = (state_q != TAIL);

  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    cnt_d   = cnt_q;
    tail_d  = tail_q;
    enc_d   = enc_q;
    valid_d = 1'b0;
    sof_d   = 1'b0;
    eof_d   = 1'b0;
    word_d  = word_q;
    case (state_q)
      IDLE, DATA: begin
        if (enable_encoder_i) begin
          sof_d = (cnt_q == 16'd0);
          if (cnt_q == LAST_BIT) begin
            cnt_d   = 16'd0;
            state_d = TAIL;
          end else begin
            cnt_d   = cnt_q + 16'd1;
            state_d = DATA;
          end
        end
      end
      TAIL: begin
        tail_d = ~tail_q;
        if (tail_q) begin
          eof_d   = 1'b1;
          word_d  = word_q + 16'd1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (emit) begin
      enc_d   = {u ^ s_q[1] ^ s_q[0], u ^ s_q[0] ^ err_flip};
      s_d     = {u, s_q[1]};
      valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      s_q     <= 2'b00;
      cnt_q   <= 16'd0;
      tail_q  <= 1'b0;
      enc_q   <= 2'b00;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
      eof_q   <= 1'b0;
      word_q  <= 16'd0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      cnt_q   <= cnt_d;
      tail_q  <= tail_d;
      enc_q   <= enc_d;
      valid_q <= valid_d;
      sof_q   <= sof_d;
      eof_q   <= eof_d;
      word_q  <= word_d;
    end
  end

  assign encoder_o = enc_q;
  assign valid_o   = valid_q;
  assign sof_o     = sof_q;
  assign eof_o     = eof_q;
  assign word_ct   = word_q;

`ifdef CONV_ERR_INJ_EN
  localparam logic [7:0] ERR_LAST = 8'(ERR_PERIOD - 1);

  logic [7:0]  err_cnt_q, err_cnt_d;
  logic        err_inj_q, err_inj_d;
  logic [15:0] bad_q, bad_d;

  // Only the transmitted symbol is corrupted; encoder state keeps the true bits.
  assign err_flip = emit && (err_cnt_q == ERR_LAST);

  always_comb begin
    err_cnt_d = err_cnt_q;
    err_inj_d = err_flip;
    bad_d     = bad_q;
    if (emit) begin
      if (err_flip) begin
        err_cnt_d = 8'd0;
        if (bad_q != 16'hFFFF) bad_d = bad_q + 16'd1;
      end else begin
        err_cnt_d = err_cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      err_cnt_q <= 8'd0;
      err_inj_q <= 1'b0;
      bad_q     <= 16'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
      err_inj_q <= err_inj_d;
      bad_q     <= bad_d;
    end
  end

  assign err_inj    = err_inj_q;
  assign bad_bit_ct = bad_q;
`else
  assign err_flip   = 1'b0;
  assign err_inj    = 1'b0;
  assign bad_bit_ct = 16'd0;
`endif

endmodule

// File: tb/tb_conv_enc_framer.sv
// Bench for conv_enc_framer (FRAME_LEN=4): directed vectors plus random frames checked against
// a convolution-by-index reference model; follows CONV_ERR_INJ_EN when that macro is defined.
module tb_conv_enc_framer;
  localparam int FL = 4;
  localparam int EP = 7;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        en  = 1'b0;
  logic        din = 1'b0;
  logic        ready_o, valid_o, sof_o, eof_o, err_inj;
  logic [1:0]  encoder_o;
  logic [15:0] word_ct, bad_bit_ct;

  conv_enc_framer #(.FRAME_LEN(FL), .ERR_PERIOD(EP)) dut (
    .clk(clk), .rst(rst), .enable_encoder_i(en), .encoder_i(din),
    .ready_o(ready_o), .encoder_o(encoder_o), .valid_o(valid_o),
    .sof_o(sof_o), .eof_o(eof_o), .word_ct(word_ct),
    .err_inj(err_inj), .bad_bit_ct(bad_bit_ct)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // Reference model: bits of the current frame, tail symbols still owed, counters.
  logic       cur[$];
  int         tail_left = 0;
  int         m_words = 0;
  int         m_syms = 0;
  int         m_bad = 0;
  logic [1:0] m_last = 2'b00;
  logic [1:0] got[$];
  int         ready_lo = 0;
  int         valid_seen = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic bit_at(input int i);
    if (i < 0 || i >= cur.size()) return 1'b0;
    return cur[i];
  endfunction

  // Symbol i of a frame is the convolution of the (zero-padded) bit sequence with the generators.
  function automatic logic [1:0] conv(input int i);
    logic g0, g1;
    g0 = bit_at(i) ^ bit_at(i - 1) ^ bit_at(i - 2);
    g1 = bit_at(i) ^ bit_at(i - 2);
    return {g0, g1};
  endfunction

  task automatic cyc(input logic en_v, input logic d_v);
    logic       e_valid, e_sof, e_eof, e_err;
    logic [1:0] e_sym;
    en = en_v;
    din = d_v;
    chk("ready", {31'd0, ready_o}, {31'd0, tail_left == 0});
    if (!ready_o) ready_lo++;
    e_valid = 1'b0; e_sof = 1'b0; e_eof = 1'b0; e_err = 1'b0;
    e_sym = m_last;
    if (tail_left > 0) begin
      e_sym = conv(FL + 2 - tail_left);
      tail_left--;
      e_valid = 1'b1;
      if (tail_left == 0) begin
        e_eof = 1'b1;
        m_words = (m_words + 1) % 65536;
        cur.delete();
      end
    end else if (en_v) begin
      cur.push_back(d_v);
      e_sym = conv(cur.size() - 1);
      e_valid = 1'b1;
      e_sof = (cur.size() == 1);
      if (cur.size() == FL) tail_left = 2;
    end
    if (e_valid) begin
      m_syms++;
`ifdef CONV_ERR_INJ_EN
      if (m_syms % EP == 0) begin
        e_sym[0] = ~e_sym[0];
        e_err = 1'b1;
        if (m_bad < 65535) m_bad++;
      end
`endif
      m_last = e_sym;
    end
    @(posedge clk);
    #1;
    chk("valid", {31'd0, valid_o}, {31'd0, e_valid});
    chk("encoder_o", {30'd0, encoder_o}, {30'd0, e_sym});
    chk("sof", {31'd0, sof_o}, {31'd0, e_sof});
    chk("eof", {31'd0, eof_o}, {31'd0, e_eof});
    chk("word_ct", {16'd0, word_ct}, m_words);
    chk("err_inj", {31'd0, err_inj}, {31'd0, e_err});
    chk("bad_bit_ct", {16'd0, bad_bit_ct}, m_bad);
    if (valid_o) begin
      got.push_back(encoder_o);
      valid_seen++;
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    en = 1'($urandom);
    din = 1'($urandom);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cur.delete();
    tail_left = 0; m_words = 0; m_syms = 0; m_bad = 0; m_last = 2'b00;
    chk("rst_encoder_o", {30'd0, encoder_o}, 32'd0);
    chk("rst_valid", {31'd0, valid_o}, 32'd0);
    chk("rst_sof", {31'd0, sof_o}, 32'd0);
    chk("rst_eof", {31'd0, eof_o}, 32'd0);
    chk("rst_word_ct", {16'd0, word_ct}, 32'd0);
    chk("rst_err_inj", {31'd0, err_inj}, 32'd0);
    chk("rst_bad_bit_ct", {16'd0, bad_bit_ct}, 32'd0);
    chk("rst_ready", {31'd0, ready_o}, 32'd1);
    got.delete();
  endtask

  // bits[0] is sent first; gap of gap_len idle cycles is inserted before bit index gap_at.
  task automatic send_frame(input logic [FL-1:0] bits, input int gap_at, input int gap_len,
                            input logic en_tail);
    for (int i = 0; i < FL; i++) begin
      if (i == gap_at) repeat (gap_len) cyc(1'b0, 1'($urandom));
      cyc(1'b1, bits[i]);
    end
    cyc(en_tail, 1'($urandom));
    cyc(en_tail, 1'($urandom));
  endtask

  task automatic cmp_got(input string tag, input logic [1:0] exp[6]);
    chk({tag, "_count"}, got.size(), 32'd6);
    for (int i = 0; i < 6 && i < got.size(); i++)
      chk(tag, {30'd0, got[i]}, {30'd0, exp[i]});
  endtask

  logic [1:0] imp_exp[6];
  logic [1:0] frm_exp[6];

  initial begin
    imp_exp = '{2'b11, 2'b10, 2'b11, 2'b00, 2'b00, 2'b00};
    frm_exp = '{2'b11, 2'b10, 2'b00, 2'b01, 2'b01, 2'b11};
    repeat (2) @(posedge clk);
    #1;
    do_reset();

    // Impulse 1,0,0,0 with enable held high through the tail.
    send_frame(4'b0001, -1, 0, 1'b1);
    cmp_got("impulse", imp_exp);

    // Frame 1,0,1,1: ready low for exactly the two tail cycles, word_ct 0->1.
    do_reset();
    ready_lo = 0;
    send_frame(4'b1101, -1, 0, 1'b0);
    cmp_got("frame", frm_exp);
    chk("ready_lo_cycles", ready_lo, 32'd2);
    chk("frame_word_ct", {16'd0, word_ct}, 32'd1);

    // Same frame with a 3-cycle enable gap between bits 2 and 3.
    do_reset();
    send_frame(4'b1101, 2, 3, 1'b0);
    cmp_got("gap", frm_exp);

    // Reset after bit 2 abandons the frame; the next frame reproduces the impulse.
    do_reset();
    cyc(1'b1, 1'b1);
    cyc(1'b1, 1'b0);
    do_reset();
    send_frame(4'b0001, -1, 0, 1'b1);
    cmp_got("post_reset", imp_exp);

    // Reset in the middle of the tail: no eof, no word count.
    do_reset();
    for (int i = 0; i < FL; i++) cyc(1'b1, 1'($urandom));
    cyc(1'b1, 1'b0);
    do_reset();
    cyc(1'b0, 1'b0);

    // Back-to-back frames with enable held high: one symbol per cycle.
    valid_seen = 0;
    for (int c = 0; c < 10 * (FL + 2); c++) cyc(1'b1, 1'($urandom));
    chk("b2b_valid_count", valid_seen, 10 * (FL + 2));
    chk("b2b_word_ct", {16'd0, word_ct}, 32'd10);

    // Random traffic with random enable gaps.
    for (int c = 0; c < 2000; c++) cyc(($urandom_range(0, 3) != 0), 1'($urandom));
    repeat (3) cyc(1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
